arp_tx: RTL and testbench



---
 rtl/arp_tx_if.sv | 26 ++
 rtl/arp_tx.sv | 160 ++++++++++++++++
 tb/tb_arp_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_tx_if.sv
// MAC TX stream between the ARP transmitter and the MAC layer.
// The master drives one packet byte per cycle plus the frame's Ethernet
// destination; the slave reports when it can accept a new frame.
interface arp_tx_if;
  logic [7:0]  mac_data;
  logic        mac_valid;
  logic        mac_last;
  logic [47:0] mac_dst;
  logic        mac_ready;

  modport master (
    output mac_data,
    output mac_valid,
    output mac_last,
    output mac_dst,
    input  mac_ready
  );

  modport slave (
    input  mac_data,
    input  mac_valid,
    input  mac_last,
    input  mac_dst,
    output mac_ready
  );
endinterface

// File: rtl/arp_tx.sv
// Transmit-side ARP engine. Builds 46-byte ARP request/reply packets
// (28 ARP bytes + 18 zero pad bytes) and streams them byte-serially into
// the MAC TX layer. Replies have priority over requests; every field is
// frozen at frame start so register updates only affect later frames.
module arp_tx #(
  parameter logic [31:0] P_DST_IP  = {8'd192, 8'd168, 8'd10, 8'd0},
  parameter logic [31:0] P_SRC_IP  = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter logic [47:0] P_SRC_MAC = 48'h0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_src_ip,
  input  logic              i_src_ip_valid,
  input  logic [31:0]       i_dst_ip,
  input  logic              i_dst_ip_valid,
  input  logic              i_trig_req,
  input  logic [47:0]       i_reply_mac,
  input  logic [31:0]       i_reply_ip,
  input  logic              i_trig_reply,
  output logic              o_busy,
  arp_tx_if.master          mac_tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_e;

  localparam logic [5:0]  LAST_BYTE = 6'd45;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  state_e      state_q;
  logic [5:0]  cnt_q;

  // Live address registers
  logic [31:0] src_ip_q;
  logic [31:0] dst_ip_q;
  logic [47:0] rep_mac_q;
  logic [31:0] rep_ip_q;
  logic        req_pend_q;
  logic        rep_pend_q;

  // Per-frame snapshot
  logic        snap_rep_q;
  logic [31:0] snap_spa_q;
  logic [47:0] snap_tha_q;
  logic [31:0] snap_tpa_q;

  // Registered outputs
  logic [7:0]  mac_data_q;
  logic        mac_valid_q;
  logic        mac_last_q;
  logic [47:0] mac_dst_q;
  logic        busy_q;

  // Whole packet laid out big-endian, byte 0 in the top bits
  logic [367:0] frame_w;
  logic [8:0]   bit_ofs_w;
  logic [7:0]   byte_d;

  assign frame_w = {16'h0001, 16'h0800, 8'h06, 8'h04,
                    (snap_rep_q ? 16'h0002 : 16'h0001),
                    P_SRC_MAC, snap_spa_q, snap_tha_q, snap_tpa_q,
                    144'h0};
  assign bit_ofs_w = {3'd0, LAST_BYTE - cnt_q} << 3;
  assign byte_d    = frame_w[bit_ofs_w +: 8];

  // Address registers, pending flags, frame FSM and output registers
  // NOTE: every register here is assigned with <=, so all right-hand sides
  // read pre-edge values and a later assignment in the block wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      src_ip_q    <= P_SRC_IP;
      dst_ip_q    <= P_DST_IP;
      rep_mac_q   <= '0;
      rep_ip_q    <= '0;
      req_pend_q  <= 1'b0;
      rep_pend_q  <= 1'b0;
      snap_rep_q  <= 1'b0;
      snap_spa_q  <= '0;
      snap_tha_q  <= '0;
      snap_tpa_q  <= '0;
      mac_data_q  <= '0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_dst_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (i_src_ip_valid) src_ip_q <= i_src_ip;
      if (i_dst_ip_valid) dst_ip_q <= i_dst_ip;
      if (i_trig_reply) begin
        rep_mac_q <= i_reply_mac;
        rep_ip_q  <= i_reply_ip;
      end

      mac_data_q  <= 8'h00;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (req_pend_q || rep_pend_q || i_trig_req || i_trig_reply) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mac_tx.mac_ready) begin
            if (rep_pend_q) begin
              rep_pend_q <= 1'b0;
              snap_rep_q <= 1'b1;
              snap_tha_q <= rep_mac_q;
              snap_tpa_q <= rep_ip_q;
              mac_dst_q  <= rep_mac_q;
            end else begin
              req_pend_q <= 1'b0;
              snap_rep_q <= 1'b0;
              snap_tha_q <= '0;
              snap_tpa_q <= dst_ip_q;
              mac_dst_q  <= BCAST_MAC;
            end
            snap_spa_q <= src_ip_q;
            cnt_q      <= '0;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          mac_data_q  <= byte_d;
          mac_valid_q <= 1'b1;
          mac_last_q  <= (cnt_q == LAST_BYTE);
          if (cnt_q == LAST_BYTE) begin
            state_q <= S_GAP;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Triggers override a same-cycle clear so the new request is kept
      if (i_trig_req)   req_pend_q <= 1'b1;
      if (i_trig_reply) rep_pend_q <= 1'b1;
    end
  end

  assign mac_tx.mac_data  = mac_data_q;
  assign mac_tx.mac_valid = mac_valid_q;
  assign mac_tx.mac_last  = mac_last_q;
  assign mac_tx.mac_dst   = mac_dst_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_arp_tx.sv
// Scoreboard bench for arp_tx: stimulus pushes the hand-built expected
// bytes of each frame into a queue; an independent monitor pops and
// compares every byte the DUT presents.
module tb_arp_tx;

  localparam logic [47:0] SRC_MAC = 48'h02_00_00_AB_CD_EF;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [47:0] dst;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_src_ip;
  logic        i_src_ip_valid;
  logic [31:0] i_dst_ip;
  logic        i_dst_ip_valid;
  logic        i_trig_req;
  logic [47:0] i_reply_mac;
  logic [31:0] i_reply_ip;
  logic        i_trig_reply;
  logic        o_busy;

  arp_tx_if mac_if ();

  arp_tx #(
    .P_SRC_MAC (SRC_MAC)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_src_ip       (i_src_ip),
    .i_src_ip_valid (i_src_ip_valid),
    .i_dst_ip       (i_dst_ip),
    .i_dst_ip_valid (i_dst_ip_valid),
    .i_trig_req     (i_trig_req),
    .i_reply_mac    (i_reply_mac),
    .i_reply_ip     (i_reply_ip),
    .i_trig_reply   (i_trig_reply),
    .o_busy         (o_busy),
    .mac_tx         (mac_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp       = 0;
  int   n_bad       = 0;
  int   frames_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected bytes written out field by field from the ARP byte map
  task automatic push_frame(input bit rep, input logic [31:0] spa,
                            input logic [47:0] tha, input logic [31:0] tpa,
                            input logic [47:0] dst);
    logic [7:0]  b [46];
    logic [47:0] sha;
    exp_t        e;
    sha = SRC_MAC;
    for (int i = 0; i < 46; i++) b[i] = 8'h00;
    b[1] = 8'h01;
    b[2] = 8'h08;
    b[4] = 8'h06;
    b[5] = 8'h04;
    b[7] = rep ? 8'h02 : 8'h01;
    for (int i = 0; i < 6; i++) begin
      b[8 + i]  = 8'(sha >> (40 - 8 * i));
      b[18 + i] = 8'(tha >> (40 - 8 * i));
    end
    for (int i = 0; i < 4; i++) begin
      b[14 + i] = 8'(spa >> (24 - 8 * i));
      b[24 + i] = 8'(tpa >> (24 - 8 * i));
    end
    for (int i = 0; i < 46; i++) begin
      e.data = b[i];
      e.last = (i == 45);
      e.dst  = dst;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare each presented byte and enforce the inter-frame gap
  initial begin : monitor
    exp_t e;
    int   idx       = 0;
    logic prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        idx       = 0;
        prev_last = 1'b0;
      end else begin
        if (prev_last) check("gap_after_last", mac_if.mac_valid, 1'b0);
        prev_last = 1'b0;
        if (mac_if.mac_valid) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_byte_%0d", idx), mac_if.mac_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("data_b%0d", idx), mac_if.mac_data, e.data);
            check($sformatf("last_b%0d", idx), mac_if.mac_last, e.last);
            check($sformatf("dst_b%0d", idx), mac_if.mac_dst, e.dst);
          end
          idx++;
          if (mac_if.mac_last) begin
            frames_seen++;
            prev_last = 1'b1;
            idx       = 0;
          end
        end
      end
    end
  end

  task automatic pulse(input logic req, input logic rep);
    @(posedge clk); #1;
    i_trig_req   = req;
    i_trig_reply = rep;
    @(posedge clk); #1;
    i_trig_req   = 1'b0;
    i_trig_reply = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    @(negedge clk);
    while (!mac_if.mac_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", mac_if.mac_valid, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    i_rst          = 1'b1;
    i_src_ip       = '0;
    i_src_ip_valid = 1'b0;
    i_dst_ip       = '0;
    i_dst_ip_valid = 1'b0;
    i_trig_req     = 1'b0;
    i_reply_mac    = '0;
    i_reply_ip     = '0;
    i_trig_reply   = 1'b0;
    mac_if.mac_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mac_if.mac_valid, 1'b0);
    check("rst_last",  mac_if.mac_last,  1'b0);
    check("rst_data",  mac_if.mac_data,  8'h00);
    check("rst_dst",   mac_if.mac_dst,   48'h0);
    check("rst_busy",  o_busy,           1'b0);
    i_rst = 1'b0;

    // Request with default addresses; byte 0 registered two cycles after WAIT
    push_frame(1'b0, 32'hC0A80A01, 48'h0, 32'hC0A80A00, BCAST);
    pulse(1'b1, 1'b0);
    check("busy_in_wait", o_busy, 1'b1);
    @(posedge clk); #1;
    check("lat_t2_valid", mac_if.mac_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_t3_valid", mac_if.mac_valid, 1'b1);
    drain();
    check("idle_busy", o_busy, 1'b0);

    // Reply to a captured requester
    i_reply_mac = 48'h11_22_33_44_55_66;
    i_reply_ip  = 32'hC0A80A05;
    push_frame(1'b1, 32'hC0A80A01, 48'h11_22_33_44_55_66, 32'hC0A80A05, 48'h11_22_33_44_55_66);
    pulse(1'b0, 1'b1);
    drain();

    // Simultaneous triggers: reply first, then request, gap between
    i_reply_mac = 48'hA1_B2_C3_D4_E5_F6;
    i_reply_ip  = 32'hC0A80A22;
    push_frame(1'b1, 32'hC0A80A01, 48'hA1_B2_C3_D4_E5_F6, 32'hC0A80A22, 48'hA1_B2_C3_D4_E5_F6);
    push_frame(1'b0, 32'hC0A80A01, 48'h0, 32'hC0A80A00, BCAST);
    pulse(1'b1, 1'b1);
    drain();
    check("frames_after_prio", frames_seen, 4);

    // Backpressure: WAIT held while ready is low; repeat trigger does not queue
    mac_if.mac_ready = 1'b0;
    push_frame(1'b0, 32'hC0A80A01, 48'h0, 32'hC0A80A00, BCAST);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("bp_busy",  o_busy,           1'b1);
    check("bp_valid", mac_if.mac_valid, 1'b0);
    mac_if.mac_ready = 1'b1;
    drain();
    check("frames_after_bp", frames_seen, 5);

    // Snapshot: address updates and a trigger mid-frame affect the next frame only
    push_frame(1'b0, 32'hC0A80A01, 48'h0, 32'hC0A80A00, BCAST);
    pulse(1'b1, 1'b0);
    wait_valid(20);
    repeat (5) @(posedge clk);
    #1;
    push_frame(1'b0, 32'hC0A80A09, 48'h0, 32'hC0A80A07, BCAST);
    i_src_ip       = 32'hC0A80A09;
    i_src_ip_valid = 1'b1;
    i_dst_ip       = 32'hC0A80A07;
    i_dst_ip_valid = 1'b1;
    i_trig_req     = 1'b1;
    @(posedge clk); #1;
    i_src_ip_valid = 1'b0;
    i_dst_ip_valid = 1'b0;
    i_trig_req     = 1'b0;
    drain();
    check("frames_after_snap", frames_seen, 7);

    // Reset at byte 10 with a request pending
    push_frame(1'b0, 32'hC0A80A09, 48'h0, 32'hC0A80A07, BCAST);
    pulse(1'b1, 1'b0);
    wait_valid(20);
    @(posedge clk); #1;
    i_trig_req = 1'b1;
    @(posedge clk); #1;
    i_trig_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_valid", mac_if.mac_valid, 1'b0);
    check("midrst_last",  mac_if.mac_last,  1'b0);
    check("midrst_data",  mac_if.mac_data,  8'h00);
    check("midrst_dst",   mac_if.mac_dst,   48'h0);
    check("midrst_busy",  o_busy,           1'b0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_busy_after", o_busy, 1'b0);

    // Fresh frame after reset uses reset-value addresses
    push_frame(1'b0, 32'hC0A80A01, 48'h0, 32'hC0A80A00, BCAST);
    pulse(1'b1, 1'b0);
    drain();
    check("frames_total", frames_seen, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
